// File: rtl/input_debouncer_if.sv
// Debouncer signal bundle.
// Raw level/enable in; clean level, strobes, busy out.
interface input_debouncer_if;
  logic raw_in;
  logic enable;
  logic level_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output raw_in,
    output enable,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  modport slave (
    input  raw_in,
    input  enable,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface

// File: rtl/input_debouncer.sv
// Synchronise and debounce a raw level.
// Clean level plus rise/fall strobes and busy.
module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input logic               clk,
  input logic               rst,
  input_debouncer_if.slave  io
);

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } state_t;

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   level;
  logic                   rise;
  logic                   fall;

  // Synchroniser chain, free-running regardless of enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], io.raw_in};
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  // Qualification FSM with registered level and strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        S_LOW: begin
          if (io.enable && sync_q) begin
            state <= S_WAIT_HIGH;
            cnt   <= '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!io.enable || !sync_q) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (cnt == TERM) begin
            state <= S_HIGH;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (io.enable && !sync_q) begin
            state <= S_WAIT_LOW;
            cnt   <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (!io.enable || sync_q) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (cnt == TERM) begin
            state <= S_LOW;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign io.level_out  = level;
  assign io.rise_pulse = rise;
  assign io.fall_pulse = fall;
  assign io.busy       = (state == S_WAIT_HIGH) ||
                         (state == S_WAIT_LOW);

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer.
// Directed table, corner sequences, random vs model.
module tb_input_debouncer;
  localparam int S = 2;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_debouncer_if bus();

  input_debouncer #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: sampled-raw delay line plus run length
  // of enabled cycles where the synced level differs.
  bit mq[$];
  bit m_level, m_rise, m_fall, m_busy;
  int run;
  int nr, nf;

  typedef struct {
    bit raw;
    bit en;
    int ncyc;
    bit lvl;
    int rises;
    int falls;
    bit busy;
  } seg_t;

  seg_t tbl[11];

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < S; i++) mq.push_back(1'b0);
    m_level = 0;
    m_rise  = 0;
    m_fall  = 0;
    m_busy  = 0;
    run     = 0;
  endtask

  task automatic model_step();
    bit s;
    if (!rst) begin
      model_reset();
    end else begin
      s = mq.pop_front();
      mq.push_back(bus.raw_in);
      m_rise = 0;
      m_fall = 0;
      if (bus.enable && s != m_level) begin
        run++;
        if (run == D + 1) begin
          m_level = s;
          m_rise  = s;
          m_fall  = !s;
          run     = 0;
        end
      end else begin
        run = 0;
      end
      m_busy = (run > 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    nr += int'(bus.rise_pulse);
    nf += int'(bus.fall_pulse);
  endtask

  task automatic wait_level(input bit target,
                            output int n);
    n = 0;
    while (n < 60) begin
      tick();
      n++;
      if (bus.level_out == target) break;
    end
  endtask

  function automatic int outs();
    return int'({bus.level_out, bus.rise_pulse,
                 bus.fall_pulse, bus.busy});
  endfunction

  initial begin
    int n;
    int len;

    tbl[0]  = '{1'b0, 1'b1, 40, 1'b0, 0, 1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 10, 1'b0, 0, 0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 20, 1'b0, 0, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16, 1'b0, 0, 0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 20, 1'b0, 0, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 17, 1'b0, 0, 0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 40, 1'b0, 1, 1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 30, 1'b0, 0, 0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 30, 1'b1, 1, 0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 30, 1'b1, 0, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 20, 1'b0, 0, 1, 1'b0};

    rst = 1'b1;
    bus.raw_in = 1'b0;
    bus.enable = 1'b1;
    nr = 0;
    nf = 0;
    model_reset();
    #1 rst = 1'b0;
    #2 check("reset_out", outs(), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();

    // Clean rise from idle.
    bus.raw_in = 1'b1;
    wait_level(1'b1, n);
    check("rise_latency", n, S + D + 1);
    check("rise_pulse", bus.rise_pulse, 1);
    check("rise_busy", bus.busy, 0);
    tick();
    check("rise_one_cycle", bus.rise_pulse, 0);

    // Asynchronous reset mid-cycle with raw high.
    #2 rst = 1'b0;
    #1 check("async_reset_out", outs(), 0);
    model_reset();
    repeat (2) tick();
    rst = 1'b1;
    wait_level(1'b1, n);
    check("post_reset_latency", n, S + D + 1);
    check("post_reset_rise", bus.rise_pulse, 1);
    tick();

    // Segment table.
    for (int i = 0; i < 11; i++) begin
      bus.raw_in = tbl[i].raw;
      bus.enable = tbl[i].en;
      nr = 0;
      nf = 0;
      repeat (tbl[i].ncyc) tick();
      check($sformatf("seg%0d_level", i),
            bus.level_out, tbl[i].lvl);
      check($sformatf("seg%0d_rises", i), nr, tbl[i].rises);
      check($sformatf("seg%0d_falls", i), nf, tbl[i].falls);
      check($sformatf("seg%0d_busy", i),
            bus.busy, tbl[i].busy);
    end

    // Bounce train then stable high.
    bus.enable = 1'b1;
    nr = 0;
    nf = 0;
    for (int k = 0; k < 6; k++) begin
      bus.raw_in = (k % 2 == 0);
      repeat (3) tick();
    end
    check("bounce_no_rise", nr, 0);
    bus.raw_in = 1'b1;
    wait_level(1'b1, n);
    check("bounce_latency", n, S + D + 1);
    repeat (20) tick();
    check("bounce_one_rise", nr, 1);
    check("bounce_no_fall", nf, 0);

    // Enable abort during qualification.
    bus.raw_in = 1'b0;
    wait_level(1'b0, n);
    check("fall_latency", n, S + D + 1);
    repeat (3) tick();
    nr = 0;
    bus.raw_in = 1'b1;
    repeat (11) tick();
    check("abort_busy_before", bus.busy, 1);
    bus.enable = 1'b0;
    tick();
    check("abort_busy_after", bus.busy, 0);
    repeat (10) tick();
    check("abort_hold_level", bus.level_out, 0);
    check("abort_no_rise", nr, 0);
    bus.enable = 1'b1;
    wait_level(1'b1, n);
    check("reenable_latency", n, D + 1);

    // Reset in the middle of a wait.
    bus.raw_in = 1'b0;
    wait_level(1'b0, n);
    repeat (3) tick();
    bus.raw_in = 1'b1;
    repeat (15) tick();
    check("midwait_busy", bus.busy, 1);
    #2 rst = 1'b0;
    #1 check("midwait_reset_out", outs(), 0);
    model_reset();
    nr = 0;
    repeat (3) tick();
    check("midwait_no_pulse", nr, 0);
    rst = 1'b1;
    wait_level(1'b1, n);
    check("midwait_restart_latency", n, S + D + 1);

    // Random run against the reference model.
    len = 0;
    for (int c = 0; c < 3000; c++) begin
      if (len == 0) begin
        bus.raw_in = 1'($urandom_range(0, 1));
        bus.enable = ($urandom_range(0, 15) != 0);
        len = $urandom_range(1, 24);
      end
      rst = ($urandom_range(0, 399) != 0);
      len--;
      tick();
      check("rand", outs(),
            int'({m_level, m_rise, m_fall, m_busy}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Input conditioning stage that sits directly upstream of the abcd sequence FSM. It takes an asynchronous raw level, such as a push-button or external strobe, and synchronises it into the clk domain. It filters bounce with a stable-time counter and delivers a clean registered level. That level drives the FSM's single-bit input. It also provides one-cycle rise/fall strobes and a busy flag for neighbouring logic.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the synchroniser chain (legal range 2..4).
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a new level (minimum 1).
CNT_W, 5, debounce counter width. Must satisfy 2**CNT_W > DEBOUNCE_CYCLES-1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
raw_in  input  1  unsynchronised raw level.
enable  input  1  1 = filtering active; 0 = abort any pending change and hold the output.
level_out  output  1  debounced, registered level; connects to the FSM data input.
rise_pulse  output  1  one-cycle strobe in the cycle level_out first reads 1.
fall_pulse  output  1  one-cycle strobe in the cycle level_out first reads 0.
busy  output  1  1 while a candidate level change is being qualified.

Behaviour:
- Reset (rst=0, asynchronous, no clock required): all synchroniser flops 0, state S_LOW, counter 0, level_out=0, rise_pulse=0, fall_pulse=0, busy=0.
- Synchroniser: raw_in passes through SYNC_STAGES flops; sync_q is the last stage. It runs regardless of enable. Only sync_q is used by the FSM.
- FSM states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW. busy is decoded from state: 1 in the WAIT states, 0 otherwise.
- S_LOW: if enable=1 and sync_q=1, go to S_WAIT_HIGH and set cnt=0; otherwise stay.
- S_WAIT_HIGH:
  - If enable=0 or sync_q=0, return to S_LOW with cnt=0 and no pulse.
  - Else if cnt==DEBOUNCE_CYCLES-1, go to S_HIGH with level_out<=1 and rise_pulse<=1.
  - Else cnt<=cnt+1.
- S_HIGH and S_WAIT_LOW: mirror image of the above. Target is sync_q=0; acceptance sets level_out<=0 and fall_pulse<=1.
- Pulses: registered, high for exactly one cycle, coincident with the level_out change. They are 0 in every other cycle.
- Latency: raw_in is first sampled at a given edge and held constant. level_out changes on edge number SYNC_STAGES+DEBOUNCE_CYCLES+1, counting that sampling edge as 1. With defaults this is the 19th edge.
- Glitch rejection: any excursion of sync_q shorter than DEBOUNCE_CYCLES+1 cycles produces no change on level_out and no pulse. busy may assert during the excursion.
- Simultaneous events: if sync_q reverts in the same cycle cnt reaches DEBOUNCE_CYCLES-1, the revert wins and no change occurs. enable=0 also overrides acceptance in that cycle.
- Counter: never wraps; it is bounded by the DEBOUNCE_CYCLES-1 terminal and cleared on every WAIT-state entry and exit.
- Reset mid-qualification: all state returns to reset values immediately. After reset release, a raw_in already at 1 is qualified from scratch with full latency.
- enable=0 in a stable state: level_out holds. A later enable=1 with a differing sync_q starts a fresh qualification.
- All outputs are driven from flops or from state-register decode. There is no combinational path from raw_in.

Test Plan:
- Reset: assert rst=0 mid-cycle with raw_in=1 -> all outputs 0 immediately. Release rst and hold raw_in=1 -> level_out=1 and rise_pulse=1 for one cycle on the 19th edge.
- Clean rise then fall (defaults): raw_in 0->1, held 40 cycles, then 1->0 -> rise_pulse on edge 19 after the rise, fall_pulse on edge 19 after the fall, each exactly one cycle wide. busy high for 16 cycles before each change.
- Glitch: raw_in high for 10 cycles, then low -> level_out stays 0, no pulses, busy returns to 0. Repeat with 16 cycles high -> no change; with 17 cycles high -> level_out rises.
- Bounce train: 5 toggles of 3 cycles each, then stable high -> exactly one rise_pulse, which occurs 19 edges after the final 0->1 sample.
- enable abort: raw_in rises, enable dropped to 0 at cnt=8 -> busy=0 next cycle and level_out remains 0. Re-enable with raw_in still high -> full 16-cycle qualification, then level_out=1.
- Reset mid-wait: rst=0 at cnt=12 in S_WAIT_HIGH, released 3 cycles later -> no pulse emitted, and qualification restarts with the full 19-edge latency.
